// File: rtl/instr_encode_loader.sv
// Encodes field-level RV32I requests and writes them one at a time into instruction memory. Each accepted request
// produces one write on the next cycle, so the block takes one request every 2 cycles. in_ready is low while a write is in flight.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

  localparam logic signed [20:0] I_MIN = -21'sd2048;
  localparam logic signed [20:0] I_MAX = 21'sd2047;
  localparam logic signed [20:0] B_MIN = -21'sd4096;
  localparam logic signed [20:0] B_MAX = 21'sd4094;
  localparam logic signed [20:0] SH_MAX = 21'sd31;

  state_t             state;
  logic               last_q;
  logic signed [20:0] imm_s;
  logic               i_ok;
  logic               b_ok;
  logic               sh_ok;
  logic               is_shift;
  logic [31:0]        enc;
  logic               bad;

  assign imm_s    = $signed(in_imm);
  assign i_ok     = (imm_s >= I_MIN) && (imm_s <= I_MAX);
  assign b_ok     = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !in_imm[0];
  assign sh_ok    = (imm_s >= 21'sd0) && (imm_s <= SH_MAX);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // The full 21-bit immediate range is exactly the JAL range, so JAL only needs the alignment check.
  always_comb begin
    enc = '0;
    bad = 1'b0;
    case (in_class)
      3'd0: begin
        enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        bad = !i_ok;
      end
      3'd1: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        bad = !i_ok;
      end
      3'd2: begin
        enc = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
      3'd3: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
        bad = !b_ok;
      end
      3'd4: begin
        if (is_shift) begin
          enc = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          bad = !sh_ok;
        end else begin
          enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          bad = !i_ok;
        end
      end
      3'd5: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        bad = in_imm[0];
      end
      3'd6: begin
        enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        bad = !i_ok;
      end
      default: bad = 1'b1;
    endcase
    if (count == MAX_CNT) bad = 1'b1;
  end

  // imem_addr doubles as the write pointer between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
      last_q     <= 1'b0;
    end else if (start) begin
      state     <= S_ACCEPT;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (bad) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state      <= S_WRITE;
              imem_we    <= 1'b1;
              imem_wdata <= enc;
              last_q     <= in_last;
            end
          end
        end
        S_WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + ADDR_W'(1);
          count     <= count + (ADDR_W+1)'(1);
          if (last_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
